// File: rtl/quiz32_pkg.sv
// quiz32_pkg: shared state encoding, burst pattern and burst length for the quiz32 transmitter and receiver
package quiz32_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, S1 = 3'd1, S10 = 3'd2, GAP = 3'd3, HUNT = 3'd4} state_t;
  localparam int BURST_LEN = 3;
  localparam logic [BURST_LEN-1:0] BURST = 3'b101;
endpackage

// File: rtl/quiz32_rx_cnt.sv
// quiz32_rx_cnt: W-bit event counter, wraps (SAT=0) or saturates (SAT=1); ports CLK, R (async high), inc, o_val
module quiz32_rx_cnt #(
  parameter int W   = 4,
  parameter int SAT = 0
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         inc,
  output logic [W-1:0] o_val
);
  logic w_hold;
  assign w_hold = (SAT != 0) && (&o_val);
  always_ff @(posedge CLK or posedge R)
    if (R) o_val <= '0;
    else if (inc && !w_hold) o_val <= o_val + 1'b1;
endmodule

// File: rtl/quiz32_rx.sv
// quiz32_rx: "1,0,1" burst receiver; in CLK, R (async high), s; out det, err, busy, count[CNT_W], err_count[ERR_W] (counted only with QUIZ32_RX_ERR_CNT_EN)
module quiz32_rx
  import quiz32_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int ERR_W = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             s,
  output logic             det,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [ERR_W-1:0] err_count
);
  state_t r_state;
  logic   r_det, r_err, r_busy;
  logic   w_inc, w_err;
  assign w_inc = (r_state == S10) && (s == BURST[0]);
  assign w_err = (r_state == S1 && s) || (r_state == S10 && !s) || (r_state == GAP && s);
  always_ff @(posedge CLK or posedge R)
    if (R) begin
      r_state <= IDLE;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_det <= w_inc;
      r_err <= w_err;
      case (r_state)
        IDLE: begin
          r_state <= (s == BURST[2]) ? S1 : IDLE;
          r_busy  <= s;
        end
        S1: begin
          r_state <= (s == BURST[1]) ? S10 : HUNT;
          r_busy  <= 1'b1;
        end
        S10: begin
          r_state <= (s == BURST[0]) ? GAP : IDLE;
          r_busy  <= s;
        end
        GAP, HUNT: begin
          r_state <= s ? HUNT : IDLE;
          r_busy  <= s;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  assign det  = r_det;
  assign err  = r_err;
  assign busy = r_busy;
  quiz32_rx_cnt #(.W(CNT_W), .SAT(0)) u_cnt (.CLK(CLK), .R(R), .inc(w_inc), .o_val(count));
`ifdef QUIZ32_RX_ERR_CNT_EN
  quiz32_rx_cnt #(.W(ERR_W), .SAT(1)) u_err_cnt (.CLK(CLK), .R(R), .inc(w_err), .o_val(err_count));
`else
  assign err_count = '0;
`endif
endmodule
